// File: rtl/rv_defs_pkg.sv
// rv_defs_pkg: shared CSR addresses, op codes and mstatus fields for the RV CSR slice.
package rv_defs_pkg;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_XSCRATCH = 12'h7C0;
  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;
  typedef enum logic {ST_RUN, ST_TRAP} trap_state_e;
  function automatic logic [31:0] csr_apply(logic [1:0] op, logic [31:0] old, logic [31:0] opnd);
    return op == CSR_OP_RW[1:0] ? opnd :
           op == CSR_OP_RS[1:0] ? old | opnd :
           op == CSR_OP_RC[1:0] ? old & ~opnd : old;
  endfunction
endpackage

// File: rtl/rv_csr_counter.sv
// rv_csr_counter: free-running wrapping counter with enable, read as two 32-bit halves.
module rv_csr_counter #(
  parameter int G_WIDTH = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);
  logic [G_WIDTH-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + G_WIDTH'(1);
  assign lo_o = cnt_q[31:0];
  assign hi_o = 32'(cnt_q[G_WIDTH-1:32]);
endmodule

// File: rtl/rv_csr_file.sv
// rv_csr_file: machine-mode CSR file with counters, scratch registers, interrupt
// enable/pending and a one-cycle trap entry FSM.
module rv_csr_file
  import rv_defs_pkg::*;
#(
  parameter int G_COUNTER_WIDTH = 40,
  parameter int G_NUM_SCRATCH   = 1,
  parameter int G_NUM_IRQ       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 x_stall_i,
  input  logic                 x_kill_i,
  input  logic                 d_is_csr_i,
  input  logic [2:0]           d_fun_i,
  input  logic [4:0]           d_csr_imm_i,
  input  logic [11:0]          d_csr_sel_i,
  input  logic [31:0]          d_rs1_i,
  output logic [31:0]          x_rd_o,
  output logic [31:0]          x_csr_write_value_o,
  output logic                 x_illegal_o,
  input  logic                 timer_tick_i,
  input  logic [G_NUM_IRQ-1:0] irq_i,
  input  logic                 x_exception_i,
  input  logic [3:0]           x_exception_cause_i,
  input  logic                 x_mret_i,
  input  logic [31:0]          x_pc_i,
  output logic                 irq_take_o,
  output logic [31:0]          trap_vector_pc_o
);
  logic [31:0] cyc_lo, cyc_hi, tim_lo, tim_hi;
  logic [31:0] scratch_q [G_NUM_SCRATCH];
  logic [31:0] mepc_q, mcause_q, opnd, rdata;
  logic [G_NUM_IRQ-1:0] mie_q, mip_q, pend;
  logic mie_bit_q, mpie_bit_q;
  logic known, ro, wr_req, exec_ok, exc_ok, irq_ok, trap_exc, trap_irq, mret_ok, csr_we;
  logic [4:0] irq_code;
  trap_state_e state_q, state_d;

  rv_csr_counter #(.G_WIDTH(G_COUNTER_WIDTH)) u_cycle (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .lo_o(cyc_lo), .hi_o(cyc_hi)
  );
  rv_csr_counter #(.G_WIDTH(G_COUNTER_WIDTH)) u_time (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(timer_tick_i), .lo_o(tim_lo), .hi_o(tim_hi)
  );

  always_comb begin
    rdata = '0;
    known = 1'b1;
    ro = 1'b0;
    case (d_csr_sel_i)
      CSR_CYCLE:    begin rdata = cyc_lo; ro = 1'b1; end
      CSR_CYCLEH:   begin rdata = cyc_hi; ro = 1'b1; end
      CSR_TIME:     begin rdata = tim_lo; ro = 1'b1; end
      CSR_TIMEH:    begin rdata = tim_hi; ro = 1'b1; end
      CSR_MIP:      begin rdata = 32'(mip_q) << IRQ_BASE; ro = 1'b1; end
      CSR_MSTATUS:  rdata = (32'(mpie_bit_q) << MSTATUS_MPIE) | (32'(mie_bit_q) << MSTATUS_MIE);
      CSR_MIE:      rdata = 32'(mie_q) << IRQ_BASE;
      CSR_MSCRATCH: rdata = scratch_q[0];
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      default: begin
        known = 1'b0;
        for (int k = 1; k < G_NUM_SCRATCH; k++)
          if (d_csr_sel_i == CSR_XSCRATCH + 12'(k)) begin
            rdata = scratch_q[k];
            known = 1'b1;
          end
      end
    endcase
  end

  // Set/clear ops with a zero operand never write, which keeps them legal on read-only CSRs.
  assign opnd = d_fun_i inside {CSR_OP_RWI, CSR_OP_RSI, CSR_OP_RCI} ? 32'(d_csr_imm_i) : d_rs1_i;
  assign x_rd_o = rdata;
  assign x_csr_write_value_o = csr_apply(d_fun_i[1:0], rdata, opnd);
  assign wr_req = d_is_csr_i && (d_fun_i[1:0] == CSR_OP_RW[1:0] || (d_fun_i[1:0] != 2'b00 && opnd != '0));
  assign x_illegal_o = d_is_csr_i && (!known || (ro && wr_req));
  assign exec_ok = !x_stall_i && !x_kill_i;
  assign pend = mip_q & mie_q;
  assign exc_ok = x_exception_i && exec_ok;
  assign irq_ok = mie_bit_q && |pend && !x_stall_i;
  assign mret_ok = x_mret_i && exec_ok && !trap_exc && !trap_irq;
  assign csr_we = wr_req && exec_ok && !x_illegal_o && !trap_exc && !trap_irq && !mret_ok;
  assign trap_vector_pc_o = mepc_q;

  always_comb begin
    irq_code = '0;
    for (int n = G_NUM_IRQ - 1; n >= 0; n--)
      if (pend[n]) irq_code = 5'(IRQ_BASE + n);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= ST_RUN;
    else state_q <= state_d;

  always_comb state_d = state_q == ST_RUN && (exc_ok || irq_ok) ? ST_TRAP : ST_RUN;

  always_comb begin
    trap_exc = state_q == ST_RUN && exc_ok;
    trap_irq = state_q == ST_RUN && !exc_ok && irq_ok;
    irq_take_o = trap_irq;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int k = 0; k < G_NUM_SCRATCH; k++) scratch_q[k] <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mie_q <= '0;
      mip_q <= '0;
      mie_bit_q <= 1'b0;
      mpie_bit_q <= 1'b0;
    end else begin
      mip_q <= irq_i;
      if (trap_exc || trap_irq) begin
        mepc_q <= x_pc_i;
        mcause_q <= trap_irq ? {1'b1, 26'b0, irq_code} : {28'b0, x_exception_cause_i};
        mpie_bit_q <= mie_bit_q;
        mie_bit_q <= 1'b0;
      end else if (mret_ok) begin
        mie_bit_q <= mpie_bit_q;
        mpie_bit_q <= 1'b1;
      end else if (csr_we)
        case (d_csr_sel_i)
          CSR_MSTATUS: begin
            mie_bit_q <= x_csr_write_value_o[MSTATUS_MIE];
            mpie_bit_q <= x_csr_write_value_o[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q <= x_csr_write_value_o[IRQ_BASE +: G_NUM_IRQ];
          CSR_MSCRATCH: scratch_q[0] <= x_csr_write_value_o;
          CSR_MEPC:     mepc_q <= x_csr_write_value_o;
          CSR_MCAUSE:   mcause_q <= x_csr_write_value_o;
          default:
            for (int k = 1; k < G_NUM_SCRATCH; k++)
              if (d_csr_sel_i == CSR_XSCRATCH + 12'(k)) scratch_q[k] <= x_csr_write_value_o;
        endcase
    end
endmodule

// File: tb/tb_rv_csr_file.sv
// tb_rv_csr_file: directed and randomized checks of rv_csr_file against a behavioural model.
module tb_rv_csr_file;
  localparam int W = 40, NS = 3, NI = 4;
  localparam longint unsigned MASK = (64'd1 << W) - 1;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic x_stall_i, x_kill_i, d_is_csr_i, timer_tick_i, x_exception_i, x_mret_i;
  logic [2:0] d_fun_i;
  logic [4:0] d_csr_imm_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] d_rs1_i, x_pc_i, x_rd_o, x_csr_write_value_o, trap_vector_pc_o;
  logic [3:0] x_exception_cause_i;
  logic [NI-1:0] irq_i;
  logic x_illegal_o, irq_take_o;
  int tests = 0, fails = 0;
  longint unsigned m_cyc, m_tim;
  logic [31:0] m_s [NS];
  logic [31:0] m_mepc, m_mcause;
  int unsigned m_ien, m_ip;
  bit m_mie, m_mpie, m_trap;
  logic [11:0] sels [15] = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'h300, 12'h304, 12'h340,
                             12'h341, 12'h342, 12'h344, 12'h7C1, 12'h7C2, 12'h7C3, 12'h123, 12'h305};
  logic [2:0] funs [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  always #5 clk_i = ~clk_i;

  rv_csr_file #(.G_COUNTER_WIDTH(W), .G_NUM_SCRATCH(NS), .G_NUM_IRQ(NI)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i), .d_csr_imm_i(d_csr_imm_i),
    .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .x_rd_o(x_rd_o),
    .x_csr_write_value_o(x_csr_write_value_o), .x_illegal_o(x_illegal_o),
    .timer_tick_i(timer_tick_i), .irq_i(irq_i), .x_exception_i(x_exception_i),
    .x_exception_cause_i(x_exception_cause_i), .x_mret_i(x_mret_i), .x_pc_i(x_pc_i),
    .irq_take_o(irq_take_o), .trap_vector_pc_o(trap_vector_pc_o)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_cyc = 0; m_tim = 0; m_mepc = 0; m_mcause = 0; m_ien = 0; m_ip = 0;
    m_mie = 0; m_mpie = 0; m_trap = 0;
    for (int k = 0; k < NS; k++) m_s[k] = 0;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a, output bit known, output bit ro);
    known = 1; ro = 0;
    if (a == 12'hC00 || a == 12'hC80) begin ro = 1; return a[7] ? 32'(m_cyc >> 32) : 32'(m_cyc); end
    if (a == 12'hC01 || a == 12'hC81) begin ro = 1; return a[7] ? 32'(m_tim >> 32) : 32'(m_tim); end
    if (a == 12'h344) begin ro = 1; return m_ip << 16; end
    if (a == 12'h300) return m_mie * 8 + m_mpie * 128;
    if (a == 12'h304) return m_ien << 16;
    if (a == 12'h340) return m_s[0];
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    if (a[11:2] == 10'h1F0 && a[1:0] != 0 && int'(a[1:0]) < NS) return m_s[a[1:0]];
    known = 0;
    return 0;
  endfunction

  function automatic void m_write(logic [11:0] a, logic [31:0] v);
    if (a == 12'h300) begin m_mie = v[3]; m_mpie = v[7]; end
    else if (a == 12'h304) m_ien = (v >> 16) & ((1 << NI) - 1);
    else if (a == 12'h340) m_s[0] = v;
    else if (a == 12'h341) m_mepc = v;
    else if (a == 12'h342) m_mcause = v;
    else if (a[11:2] == 10'h1F0) m_s[a[1:0]] = v;
  endfunction

  // Compare the DUT against the model mid-cycle, then advance the model across one edge.
  task automatic cyc();
    logic [31:0] rd, opnd, wv;
    bit kn, ro, wr, ill, exok, exc, intr, trap;
    int ic;
    #1;
    rd = m_read(d_csr_sel_i, kn, ro);
    opnd = d_fun_i[2] ? 32'(d_csr_imm_i) : d_rs1_i;
    wv = d_fun_i[1:0] == 1 ? opnd : d_fun_i[1:0] == 2 ? (rd | opnd) : (rd & ~opnd);
    wr = d_fun_i[1:0] == 1 || opnd != 0;
    ill = d_is_csr_i && (!kn || (ro && wr));
    exok = !x_stall_i && !x_kill_i;
    exc = x_exception_i && exok;
    ic = -1;
    for (int n = NI - 1; n >= 0; n--) if (m_ip[n] && m_ien[n]) ic = n;
    intr = m_mie && ic >= 0 && !x_stall_i;
    trap = !m_trap && (exc || intr);
    chk("rd", x_rd_o, rd);
    chk("illegal", 32'(x_illegal_o), 32'(ill));
    if (d_is_csr_i) chk("wval", x_csr_write_value_o, wv);
    chk("irq_take", 32'(irq_take_o), 32'(trap && !exc));
    chk("trap_pc", trap_vector_pc_o, m_mepc);
    @(posedge clk_i);
    m_cyc = (m_cyc + 1) & MASK;
    if (timer_tick_i) m_tim = (m_tim + 1) & MASK;
    if (trap) begin
      m_mepc = x_pc_i;
      m_mcause = exc ? 32'(x_exception_cause_i) : 32'h8000_0000 + 32'(16 + ic);
      m_mpie = m_mie;
      m_mie = 0;
    end else if (x_mret_i && exok) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (d_is_csr_i && exok && !ill && wr) m_write(d_csr_sel_i, wv);
    m_ip = 32'(irq_i);
    m_trap = trap;
    @(negedge clk_i);
  endtask

  task automatic idle();
    d_is_csr_i = 0; d_fun_i = 0; d_csr_sel_i = 0; d_rs1_i = 0; d_csr_imm_i = 0;
    x_stall_i = 0; x_kill_i = 0; x_exception_i = 0; x_exception_cause_i = 0;
    x_mret_i = 0; timer_tick_i = 0;
  endtask

  task automatic csr(logic [11:0] sel, logic [2:0] fun, logic [31:0] v);
    idle();
    d_is_csr_i = 1; d_csr_sel_i = sel; d_fun_i = fun; d_rs1_i = v; d_csr_imm_i = v[4:0];
  endtask

  initial begin
    idle();
    irq_i = 0; x_pc_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    m_reset();
    d_csr_sel_i = 12'h340; #1;
    chk("reset_mscratch", x_rd_o, 0);
    chk("reset_take", 32'(irq_take_o), 0);
    chk("reset_mepc", trap_vector_pc_o, 0);
    d_csr_sel_i = 12'h300; #1;
    chk("reset_mstatus", x_rd_o, 0);
    cyc();
    csr(12'h340, 3'd1, 32'hDEAD_BEEF); cyc();
    csr(12'h340, 3'd2, 0); #1;
    chk("rs0_read", x_rd_o, 32'hDEAD_BEEF);
    chk("rs0_legal", 32'(x_illegal_o), 0);
    cyc();
    csr(12'h340, 3'd2, 0); #1;
    chk("rs0_nowrite", x_rd_o, 32'hDEAD_BEEF);
    cyc();
    csr(12'hC00, 3'd1, 32'h5); #1;
    chk("ro_write_illegal", 32'(x_illegal_o), 1);
    cyc();
    csr(12'h123, 3'd2, 0); #1;
    chk("unknown_read", x_rd_o, 0);
    chk("unknown_illegal", 32'(x_illegal_o), 1);
    cyc();
    csr(12'hC00, 3'd6, 0); #1;
    chk("ro_rsi0_legal", 32'(x_illegal_o), 0);
    cyc();
    csr(12'h300, 3'd1, 32'h8); cyc();
    csr(12'h304, 3'd1, 32'h2_0000); irq_i = 4'b0010; cyc();
    idle(); x_pc_i = 32'h100; #1;
    chk("irq_take", 32'(irq_take_o), 1);
    cyc();
    d_csr_sel_i = 12'h342; #1;
    chk("irq_mcause", x_rd_o, 32'h8000_0011);
    d_csr_sel_i = 12'h300; #1;
    chk("irq_mstatus", x_rd_o, 32'h80);
    chk("irq_mepc", trap_vector_pc_o, 32'h100);
    irq_i = 0; cyc();
    idle(); x_mret_i = 1; cyc();
    idle(); d_csr_sel_i = 12'h300; #1;
    chk("mret_mstatus", x_rd_o, 32'h88);
    cyc();
    csr(12'h340, 3'd1, 32'h1234); x_exception_i = 1; x_exception_cause_i = 4'd5; x_pc_i = 32'h200; cyc();
    idle(); d_csr_sel_i = 12'h340; #1;
    chk("exc_drops_write", x_rd_o, 32'hDEAD_BEEF);
    d_csr_sel_i = 12'h342; #1;
    chk("exc_mcause", x_rd_o, 32'h5);
    cyc();
    idle(); d_csr_sel_i = 12'hC80;
    force dut.u_cycle.cnt_q = 40'hFF_FFFF_FFFE;
    #1 release dut.u_cycle.cnt_q;
    m_cyc = 64'hFF_FFFF_FFFE;
    #1 chk("cycleh_pre", x_rd_o, 32'hFF);
    cyc();
    cyc();
    #1 chk("cycleh_wrap", x_rd_o, 0);
    d_csr_sel_i = 12'hC00; #1;
    chk("cycle_wrap", x_rd_o, 0);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      d_is_csr_i = $urandom_range(0, 3) != 0;
      d_csr_sel_i = sels[$urandom_range(0, 14)];
      d_fun_i = funs[$urandom_range(0, 5)];
      d_rs1_i = $urandom_range(0, 3) == 0 ? 0 : $urandom;
      d_csr_imm_i = 5'($urandom);
      x_stall_i = $urandom_range(0, 9) == 0;
      x_kill_i = $urandom_range(0, 9) == 0;
      x_exception_i = $urandom_range(0, 19) == 0;
      x_exception_cause_i = 4'($urandom);
      x_mret_i = $urandom_range(0, 15) == 0;
      x_pc_i = $urandom;
      timer_tick_i = 1'($urandom);
      if ($urandom_range(0, 7) == 0) irq_i = NI'($urandom);
      cyc();
    end
    idle(); irq_i = 0; x_pc_i = 32'h300; x_exception_i = 1; x_exception_cause_i = 4'd2; cyc();
    idle();
    #2 rst_i = 1;
    #1 chk("rst_trap_pc", trap_vector_pc_o, 0);
    chk("rst_take", 32'(irq_take_o), 0);
    d_csr_sel_i = 12'h342; #1;
    chk("rst_mcause", x_rd_o, 0);
    d_csr_sel_i = 12'hC00; #1;
    chk("rst_cycle", x_rd_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    m_reset();
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv_csr_file.md
RV_CSR_FILE -- requirements
Module: rv_csr_file

Interface
REQ-001 The block SHALL expose parameter G_COUNTER_WIDTH, default 40, giving the width of the cycle and time counters (legal 33..64).
REQ-002 The block SHALL expose parameter G_NUM_SCRATCH, default 1, giving the number of scratch registers (legal 1..4).
REQ-003 The block SHALL expose parameter G_NUM_IRQ, default 1, giving the number of external interrupt lines (legal 1..16).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 x_stall_i / x_kill_i  in  1 each  execute-stage stall / kill.
REQ-007 d_is_csr_i  in  1; d_fun_i  in  3; d_csr_imm_i  in  5; d_csr_sel_i  in  12; d_rs1_i  in  32; together they form the decoded CSR instruction.
REQ-008 x_rd_o  out  32  old CSR value; x_csr_write_value_o  out  32  computed new value; x_illegal_o  out  1  unknown CSR, or write to a read-only CSR.
REQ-009 timer_tick_i  in  1  time-counter increment strobe.
REQ-010 irq_i  in  G_NUM_IRQ  level-sensitive interrupts; x_exception_i  in  1; x_exception_cause_i  in  4; x_mret_i  in  1; x_pc_i  in  32.
REQ-011 irq_take_o  out  1  interrupt accepted this cycle; trap_vector_pc_o  out  32  mepc, used for mret.

Function
REQ-012 Read mux: cycle 0xC00/0xC80, time 0xC01/0xC81, mstatus 0x300, mie 0x304, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, extra scratch k 0x7C0+k (k=1..G_NUM_SCRATCH-1); it SHALL be combinational; high halves are zero-extended counter bits [W-1:32].
REQ-013 Any other address SHALL read 0 and assert x_illegal_o while d_is_csr_i=1.
REQ-014 Operand SHALL be the zero-extended d_csr_imm_i for the RWI/RSI/RCI ops, else d_rs1_i; RW replaces, RS ORs, RC AND-NOTs.
REQ-015 Write commit SHALL occur on the clock edge where d_is_csr_i=1, !x_stall_i, !x_kill_i and !x_illegal_o.
REQ-016 For RS/RC/RSI/RCI the write SHALL be suppressed when the operand is 0, so read-only CSRs are legal in that case.
REQ-017 Writes to counters or mip (read-only) with a non-zero operand or RW op SHALL assert x_illegal_o and not commit.
REQ-018 Cycle counter SHALL increment every cycle and time counter on each timer_tick_i cycle; both wrap modulo 2^W.
REQ-019 mip[16+n] SHALL mirror irq_i[n] with one register stage; other mip bits read 0.
REQ-020 mie SHALL store only bits 16..16+G_NUM_IRQ-1; mstatus SHALL store MIE (bit 3) and MPIE (bit 7) only.
REQ-021 Trap FSM states: RUN, TRAP.
REQ-022 In RUN, an accepted exception, or an interrupt with mstatus.MIE=1 and (mip&mie)!=0 while !x_stall_i, SHALL move the FSM to TRAP for exactly one cycle.
REQ-023 On trap entry: mepc<=x_pc_i, MPIE<=MIE, MIE<=0, mcause<={irq,27'b0,cause}.
REQ-024 The interrupt cause SHALL be 16+lowest pending index; exception cause is x_exception_cause_i with bit31=0.
REQ-025 Priority on one edge: exception > interrupt > mret > CSR write; the lower-priority CSR write SHALL be dropped.
REQ-026 irq_take_o SHALL be 1 in the cycle an interrupt entry is accepted.
REQ-027 x_mret_i (not stalled or killed) SHALL set MIE<=MPIE and MPIE<=1; trap_vector_pc_o SHALL always equal mepc.

Reset
REQ-028 On rst_i, all counters, scratch registers, mepc, mcause, mie and mip SHALL be 0; MIE=0, MPIE=0; FSM=RUN; irq_take_o=0.
REQ-029 Reset mid-trap SHALL abandon the trap with no partial mepc/mcause update.

Structure
REQ-030 CSR addresses, op codes (CSR_OP_*) and mstatus bit indices SHALL live in the shared rv_defs definitions.
REQ-031 One sub-module, rv_csr_counter (width-parametrised, enable, split 32-bit read), SHALL be instantiated twice.

Verification
REQ-032 CSRRW 0x340 rs1=0xDEADBEEF, then CSRRS 0x340 rs1=0 -> second read 0xDEADBEEF, with no write.
REQ-033 W=40, cycle preloaded near 0xFF_FFFFFFFF -> 0xC80 reads 0xFF, then 0x00 after wrap.
REQ-034 CSRRW 0xC00 -> x_illegal_o=1, cycle is not modified; read of 0x123 -> 0, x_illegal_o=1.
REQ-035 MIE=1, mie[17]=1, irq_i[1]=1, x_pc_i=0x100 -> irq_take_o=1, mepc=0x100, mcause=0x80000011, MIE=0; then mret -> MIE=1.
REQ-036 Exception and CSR write to mscratch on the same edge -> mscratch unchanged, mcause=exception cause.
REQ-037 rst_i asserted asynchronously mid-cycle during TRAP -> all outputs reach their reset values before the next edge.
